// File: rtl/secure_bank_pkg.sv
// Shared types and width helpers for the password-gated register bank.
package secure_bank_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_PASS = 2'd1,
        GRANT     = 2'd2,
        LOCKOUT   = 2'd3
    } state_e;

    // Channel-select width, never below one bit even for a single channel.
    function automatic int unsigned ch_sel_w(input int unsigned num_ch);
        return ($clog2(num_ch) > 0) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/chan_reg.sv
// One channel register: synchronous active-low reset, write-enabled load.
module chan_reg #(
    parameter int unsigned DATA_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [DATA_W-1:0] d_i,
    output logic [DATA_W-1:0] q_o
);

    logic [DATA_W-1:0] q_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            q_q <= '0;
        end else if (we_i) begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/secure_reg_bank.sv
// Password-gated register bank: session FSM, try/lock counters, NUM_CH channel registers.
// Optional lockout on repeated wrong passwords enabled by defining SECURE_BANK_LOCKOUT_EN.
module secure_reg_bank
    import secure_bank_pkg::*;
#(
    parameter int unsigned DATA_W      = 4,
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned PASS_W      = 4,
    parameter int unsigned MAX_TRIES   = 3,
    parameter int unsigned LOCK_CYCLES = 16
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [PASS_W-1:0]             orginal_pass,
    input  logic                          request,
    input  logic                          confirm,
    input  logic [PASS_W-1:0]             pass_data,
    input  logic [DATA_W-1:0]             din,
    input  logic [ch_sel_w(NUM_CH)-1:0]   ch_sel,
    output logic [NUM_CH*DATA_W-1:0]      qout,
    output logic                          granted,
    output logic                          locked,
    output logic                          err
);

    state_e      state_q, state_d;
    logic        err_q, err_d;
    logic        wr_en;
    logic        ch_ok;
    logic [NUM_CH-1:0] we;

`ifdef SECURE_BANK_LOCKOUT_EN
    localparam int unsigned TRIES_W = 4;
    localparam int unsigned LOCK_W  = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    logic [TRIES_W-1:0] tries_q, tries_d;
    logic [LOCK_W-1:0]  lock_q, lock_d;
`endif

    assign ch_ok = (32'(ch_sel) < NUM_CH);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
`ifdef SECURE_BANK_LOCKOUT_EN
            tries_q <= '0;
            lock_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
`ifdef SECURE_BANK_LOCKOUT_EN
            tries_q <= tries_d;
            lock_q  <= lock_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        wr_en   = 1'b0;
`ifdef SECURE_BANK_LOCKOUT_EN
        tries_d = tries_q;
        lock_d  = lock_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (request) state_d = WAIT_PASS;
            end
            WAIT_PASS: begin
                // Dropping request aborts the session; the try count survives.
                if (!request) begin
                    state_d = IDLE;
                end else if (confirm) begin
                    if (pass_data == orginal_pass) begin
                        state_d = GRANT;
`ifdef SECURE_BANK_LOCKOUT_EN
                        tries_d = '0;
`endif
                    end else begin
                        err_d = 1'b1;
`ifdef SECURE_BANK_LOCKOUT_EN
                        tries_d = tries_q + TRIES_W'(1);
                        if (tries_d == TRIES_W'(MAX_TRIES)) begin
                            state_d = LOCKOUT;
                            lock_d  = LOCK_W'(LOCK_CYCLES - 1);
                        end
`endif
                    end
                end
            end
            GRANT: begin
                if (!request) begin
                    state_d = IDLE;
                end else if (confirm) begin
                    if (ch_ok) begin
                        wr_en   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOCKOUT: begin
`ifdef SECURE_BANK_LOCKOUT_EN
                if (lock_q == '0) begin
                    state_d = IDLE;
                    tries_d = '0;
                end else begin
                    lock_d = lock_q - LOCK_W'(1);
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        assign we[k] = wr_en && (32'(ch_sel) == k);

        chan_reg #(
            .DATA_W (DATA_W)
        ) u_chan_reg (
            .clk_i  (CLK),
            .rst_ni (RST),
            .we_i   (we[k]),
            .d_i    (din),
            .q_o    (qout[k*DATA_W +: DATA_W])
        );
    end

    assign granted = (state_q == GRANT);
    assign err     = err_q;
`ifdef SECURE_BANK_LOCKOUT_EN
    assign locked  = (state_q == LOCKOUT);
`else
    assign locked  = 1'b0;
`endif

endmodule

// File: tb/tb_secure_reg_bank.sv
// Directed bench: two instances (2 and 3 channels) with hand-computed expectations.
module tb_secure_reg_bank;

    logic        CLK = 1'b0;
    logic        RST;
    logic [3:0]  orginal_pass;
    logic [3:0]  pass_data;
    logic [3:0]  din;

    logic        request, confirm;
    logic [0:0]  ch_sel;
    logic [7:0]  qout;
    logic        granted, locked, err;

    logic        request3, confirm3;
    logic [1:0]  ch_sel3;
    logic [11:0] qout3;
    logic        granted3, locked3, err3;

    int total = 0;
    int bad   = 0;
    int lcnt;

`ifdef SECURE_BANK_LOCKOUT_EN
    localparam logic LOCK_EN = 1'b1;
`else
    localparam logic LOCK_EN = 1'b0;
`endif

    always #5 CLK = ~CLK;

    secure_reg_bank #(
        .DATA_W      (4),
        .NUM_CH      (2),
        .PASS_W      (4),
        .MAX_TRIES   (3),
        .LOCK_CYCLES (16)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .orginal_pass (orginal_pass),
        .request      (request),
        .confirm      (confirm),
        .pass_data    (pass_data),
        .din          (din),
        .ch_sel       (ch_sel),
        .qout         (qout),
        .granted      (granted),
        .locked       (locked),
        .err          (err)
    );

    secure_reg_bank #(
        .DATA_W      (4),
        .NUM_CH      (3),
        .PASS_W      (4),
        .MAX_TRIES   (3),
        .LOCK_CYCLES (16)
    ) dut3 (
        .CLK          (CLK),
        .RST          (RST),
        .orginal_pass (orginal_pass),
        .request      (request3),
        .confirm      (confirm3),
        .pass_data    (pass_data),
        .din          (din),
        .ch_sel       (ch_sel3),
        .qout         (qout3),
        .granted      (granted3),
        .locked       (locked3),
        .err          (err3)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        RST = 1'b0; orginal_pass = 4'hA; pass_data = 4'h0; din = 4'h0;
        request = 1'b0; confirm = 1'b0; ch_sel = 1'b0;
        request3 = 1'b0; confirm3 = 1'b0; ch_sel3 = 2'd0;
        tick(); tick();
        chk("rst_qout", 16'(qout), 16'h0);
        chk("rst_granted", 16'(granted), 16'h0);
        chk("rst_locked", 16'(locked), 16'h0);
        chk("rst_err", 16'(err), 16'h0);
        chk("rst_qout3", 16'(qout3), 16'h0);
        RST = 1'b1;

        // Three-channel instance: out-of-range select, then valid write to ch 2.
        request3 = 1'b1; tick();
        pass_data = 4'hA; confirm3 = 1'b1; tick();
        chk("c3_granted", 16'(granted3), 16'h1);
        ch_sel3 = 2'd3; din = 4'h7; tick();
        chk("c3_oor_err", 16'(err3), 16'h1);
        chk("c3_oor_granted", 16'(granted3), 16'h1);
        chk("c3_oor_qout", 16'(qout3), 16'h000);
        ch_sel3 = 2'd2; tick();
        chk("c3_wr_qout", 16'(qout3), 16'h700);
        chk("c3_wr_granted", 16'(granted3), 16'h0);
        chk("c3_wr_err", 16'(err3), 16'h0);
        request3 = 1'b0; confirm3 = 1'b0; tick();

        // Basic session: correct password, write 5 to channel 1.
        request = 1'b1; confirm = 1'b1; pass_data = 4'h3; tick();
        chk("idle_confirm_ignored_err", 16'(err), 16'h0);
        confirm = 1'b0; tick();
        pass_data = 4'hA; confirm = 1'b1; tick();
        chk("t1_granted", 16'(granted), 16'h1);
        chk("t1_err", 16'(err), 16'h0);
        ch_sel = 1'b1; din = 4'h5; tick();
        chk("t1_qout", 16'(qout), 16'h50);
        chk("t1_granted_off", 16'(granted), 16'h0);
        request = 1'b0; confirm = 1'b0; tick();

        // One wrong password, then correct, then write 9 to channel 0.
        request = 1'b1; tick();
        pass_data = 4'h3; confirm = 1'b1; tick();
        chk("t2_err_pulse", 16'(err), 16'h1);
        chk("t2_granted", 16'(granted), 16'h0);
        confirm = 1'b0; tick();
        chk("t2_err_clear", 16'(err), 16'h0);
        pass_data = 4'hA; confirm = 1'b1; tick();
        chk("t2_granted_on", 16'(granted), 16'h1);
        ch_sel = 1'b0; din = 4'h9; tick();
        chk("t2_qout", 16'(qout), 16'h59);
        request = 1'b0; confirm = 1'b0; tick();

        // Three wrong passwords with confirm held high.
        request = 1'b1; tick();
        pass_data = 4'h3; confirm = 1'b1;
        tick(); chk("t3_err1", 16'(err), 16'h1);
        tick(); chk("t3_err2", 16'(err), 16'h1);
        tick(); chk("t3_err3", 16'(err), 16'h1);
        chk("t3_locked", 16'(locked), 16'(LOCK_EN));
        pass_data = 4'hA;
        if (LOCK_EN) begin
            lcnt = 1;
            tick();
            chk("t3_lock_err", 16'(err), 16'h0);
            chk("t3_lock_granted", 16'(granted), 16'h0);
            for (int i = 0; i < 40 && locked; i++) begin
                lcnt++;
                tick();
            end
            chk("t3_lock_len", 16'(lcnt), 16'd16);
            chk("t3_lock_qout", 16'(qout), 16'h59);
            chk("t3_after_granted", 16'(granted), 16'h0);
            tick();
            chk("t3_wait_granted", 16'(granted), 16'h0);
        end
        tick();
        chk("t3_regrant", 16'(granted), 16'h1);
        chk("t3_regrant_locked", 16'(locked), 16'h0);

        // Abort in GRANT: no write.
        request = 1'b0; confirm = 1'b0; ch_sel = 1'b1; din = 4'hF; tick();
        chk("t4_abort_granted", 16'(granted), 16'h0);
        tick();
        chk("t4_abort_qout", 16'(qout), 16'h59);

        // Aborting keeps the try count: 1 wrong, abort, then 2 wrong locks out.
        request = 1'b1; tick();
        pass_data = 4'h3; confirm = 1'b1; tick();
        request = 1'b0; confirm = 1'b0; tick();
        request = 1'b1; tick();
        confirm = 1'b1; tick();
        chk("t5_try2_locked", 16'(locked), 16'h0);
        tick();
        chk("t5_try3_locked", 16'(locked), 16'(LOCK_EN));
        confirm = 1'b0; tick(); tick(); tick();
        chk("t5_mid_locked", 16'(locked), 16'(LOCK_EN));

        // Reset mid-lockout clears everything at that edge.
        RST = 1'b0; tick();
        chk("t5_rst_locked", 16'(locked), 16'h0);
        chk("t5_rst_qout", 16'(qout), 16'h0);
        chk("t5_rst_qout3", 16'(qout3), 16'h0);
        chk("t5_rst_granted", 16'(granted), 16'h0);
        chk("t5_rst_err", 16'(err), 16'h0);
        request = 1'b0; RST = 1'b1; tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/secure_reg_bank.md
# secure_reg_bank

Password-gated, parametrised register bank; successor of the two-channel left/right password-register system. A request opens a session, a confirmed password grants one write of `din` into a selected channel register, and repeated wrong passwords lock the bank out for a fixed time. It sits between the front-panel input logic (switches/buttons, already debounced) and the display drivers that consume `qout`.

## Interface
Parameters:
- `DATA_W`, default 4: width of each channel register and of `din`.
- `NUM_CH`, default 2: number of channel registers; channel 0 is the former left register, channel 1 the former right.
- `PASS_W`, default 4: password width.
- `MAX_TRIES`, default 3: consecutive wrong passwords that trigger lockout (1..15).
- `LOCK_CYCLES`, default 16: lockout duration in clock cycles (≥1).

Ports:
- `CLK`, input, 1: single clock; everything is on the rising edge.
- `RST`, input, 1: synchronous, active-low reset.
- `orginal_pass`, input, `PASS_W`: stored password, quasi-static.
- `request`, input, 1: level; high opens and holds a session.
- `confirm`, input, 1: single-cycle strobe; samples `pass_data` or commits a write.
- `pass_data`, input, `PASS_W`: entered password.
- `din`, input, `DATA_W`: write data.
- `ch_sel`, input, `$clog2(NUM_CH)` (min 1): target channel.
- `qout`, output, `NUM_CH*DATA_W`: channel k in bits `[k*DATA_W +: DATA_W]`.
- `granted`, output, 1: high while the state is GRANT.
- `locked`, output, 1: high while the state is LOCKOUT.
- `err`, output, 1: one-cycle pulse on a wrong password or an out-of-range `ch_sel`.

## Operation
- States: IDLE, WAIT_PASS, GRANT, LOCKOUT.
- IDLE: `request`=1 moves to WAIT_PASS. `confirm` is ignored, including when it arrives in the same cycle as `request`.
- WAIT_PASS, on `confirm`:
  - `pass_data==orginal_pass`: go to GRANT and clear the try counter.
  - Otherwise: pulse `err` and increment tries. If tries reaches `MAX_TRIES`, go to LOCKOUT and load the lock counter with `LOCK_CYCLES-1`. Otherwise stay in WAIT_PASS.
- GRANT, on `confirm`:
  - `ch_sel<NUM_CH`: write `din` into channel `ch_sel`, then return to IDLE (one write per grant).
  - `ch_sel>=NUM_CH`: no write, pulse `err`, stay in GRANT.
- LOCKOUT: ignores `request` and `confirm`. The counter decrements each cycle; at 0 the state goes to IDLE and tries clear.
- `request` low in WAIT_PASS or GRANT: return to IDLE with no write. The try counter is retained, so aborting does not reset the attempt count.
- Channel registers change only on a GRANT write. No other path modifies them.

## Timing
- Reset (`RST`=0 at an edge): state IDLE, tries 0, lock counter 0, all `qout` 0, `granted`=0, `locked`=0, `err`=0. Reset in any state, including mid-lockout, takes effect at that edge.
- `request` at edge n puts the state in WAIT_PASS after edge n.
- Correct `confirm` at edge m: `granted`=1 after edge m.
- Write `confirm` at edge w: the new `qout` slice and `granted`=0 are visible after edge w. Write latency is 1 cycle.
- `err` is registered: high for exactly the cycle after the offending edge.
- LOCKOUT lasts exactly `LOCK_CYCLES` cycles, with `locked`=1 throughout, then IDLE.
- `confirm` held high for several cycles is treated as repeated strobes. No edge detection is done here.

## Configuration
- `SECURE_BANK_LOCKOUT_EN` defined: try counter, LOCKOUT state and `locked` behave as above.
- Not defined:
  - No try counter and no LOCKOUT state.
  - A wrong password pulses `err` and the state stays in WAIT_PASS indefinitely.
  - `locked` is tied to 0.
  - `MAX_TRIES` and `LOCK_CYCLES` are unused.

## Structure
- Package `secure_bank_pkg`: state enum (IDLE, WAIT_PASS, GRANT, LOCKOUT) and the `CH_SEL_W` width helper `($clog2(NUM_CH)>0 ? $clog2(NUM_CH) : 1)`.
- Sub-module `chan_reg`: `DATA_W` register with synchronous active-low reset and write enable, instantiated `NUM_CH` times via generate.
- The FSM, try counter and lock counter live in the top.

## Test plan
- Reset, then `request`=1, `pass_data`=`orginal_pass`=4'hA, `confirm`, then `ch_sel`=1, `din`=4'h5, `confirm` → `qout`=8'h50, `granted` 1 for one state, back to IDLE.
- Wrong password 4'h3 once, then correct, then a write to ch 0 of 4'h9 → `err` pulses once, `qout[3:0]`=4'h9.
- Three wrong passwords (`MAX_TRIES`=3, `LOCK_CYCLES`=16) → `locked`=1 for exactly 16 cycles, `confirm` ignored throughout, `qout` unchanged. Without the macro: three `err` pulses and still in WAIT_PASS.
- `NUM_CH`=3, GRANT with `ch_sel`=3 → `err` pulse, no write, still GRANT; then `ch_sel`=2 → write.
- `request` dropped in GRANT, then reset asserted mid-LOCKOUT → IDLE, no write; after reset all outputs 0.
